mod_exp_ctrl: RTL and testbench
===============================

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 The block SHALL have parameter BITLEN, default 512, giving the modulus/operand width.
REQ-002 The block SHALL have parameter ELEN_W, default 10, giving the exponent-length field width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: start  in  1  request a new exponentiation; sampled only in IDLE.
REQ-007 Port: E  in  BITLEN  exponent; latched on accepted start.
REQ-008 Port: e_len  in  ELEN_W  number of exponent bits to process; latched on accepted start.
REQ-009 Port: mp_start  out  1  start level to the Montgomery product unit.
REQ-010 Port: mp_op_code  out  2  operation: OPXX=0 square, OPXM=1 multiply by base, OPX1=2 multiply by 1 (leave Montgomery domain).
REQ-011 Port: mp_stop  in  1  Montgomery product unit completion flag.
REQ-012 Port: mp_P  in  BITLEN+1  Montgomery product unit result.
REQ-013 Port: result  out  BITLEN  final exponentiation result.
REQ-014 Port: busy  out  1  high from accepted start until done.
REQ-015 Port: done  out  1  one-cycle pulse when result is valid.
REQ-016 Port: err  out  1  high when the last request had e_len > BITLEN; cleared on next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, GAP, NEXT, FINISH.
REQ-018 IDLE: start=1 latches E, e_len, sets bit index i=e_len-1, op=OPXX, busy=1; if e_len=0 op=OPX1; if e_len>BITLEN set err, pulse done next cycle, return to IDLE with result unchanged.
REQ-019 ISSUE: assert mp_start=1 with mp_op_code=op; next state WAIT.
REQ-020 WAIT: hold mp_start=1 and mp_op_code stable until mp_stop=1 is sampled; next state GAP.
REQ-021 GAP: drive mp_start=0 for exactly one cycle; next state NEXT (mp_stop high in GAP SHALL be ignored).
REQ-022 NEXT: after OPXX, op=OPXM if E[i]=1; otherwise decrement i, op=OPXX if i was >0, else OPX1; after OPXM, same decrement rule; after OPX1, go to FINISH; non-FINISH outcomes go to ISSUE.
REQ-023 Every exponent bit SHALL receive one square; leading zeros are not skipped (accumulator is preloaded with Montgomery one).
REQ-024 Total issued ops SHALL equal e_len + popcount(E[e_len-1:0]) + 1.
REQ-025 When mp_stop is sampled in WAIT for an OPX1 op, result SHALL capture mp_P[BITLEN-1:0].
REQ-026 FINISH: done=1 for one cycle, busy=0 thereafter, return to IDLE.
REQ-027 start asserted while busy SHALL be ignored; E/e_len changes while busy SHALL have no effect.
REQ-028 mp_start SHALL never be asserted in IDLE, GAP, NEXT or FINISH.
REQ-029 The minimum interval between consecutive ops SHALL be mp latency + 3 cycles (ISSUE, GAP, NEXT).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, mp_start=0, mp_op_code=OPXX, busy=0, done=0, err=0, result=0, i=0.
REQ-031 Reset during any op SHALL abandon it; after release the block SHALL accept a fresh start with no residual op.

Structure
REQ-032 Op-code constants OPXX/OPXM/OPX1 and the FSM state encoding SHALL reside in a shared package used with the Montgomery product unit.
REQ-033 No sub-module is required; the block is a single FSM plus index counter and result register.

Verification
REQ-034 Bench SHALL pair the block with a behavioural Montgomery model (fixed 8-cycle latency), M=589, base 435.
REQ-035 E=5, e_len=3 -> op sequence XX,XM,XX,XX,XM,X1 (6 ops), result=63, single done pulse.
REQ-036 e_len=0 -> exactly one OPX1 op, then done; result = model output for OPX1.
REQ-037 e_len=BITLEN+1 -> no mp_start, err=1, done one cycle after start.
REQ-038 start re-pulsed during WAIT of op 2 with E=5 -> ignored; sequence and result as in REQ-035.
REQ-039 rst_n low during WAIT of op 3 -> mp_start, busy low at once; new start with E=3, e_len=2 -> XX,XM,XX,XM,X1, done.

Source files
------------

// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller and the Montgomery product unit.
// Op codes and controller state encoding live here so both sides agree on them.
package mod_exp_ctrl_pkg;

    typedef enum logic [1:0] {
        OPXX = 2'd0,
        OPXM = 2'd1,
        OPX1 = 2'd2
    } mp_op_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StWait   = 3'd2,
        StGap    = 3'd3,
        StNext   = 3'd4,
        StFinish = 3'd5
    } state_e;

    // Op following a processed exponent bit: square the next bit, or leave Montgomery domain.
    function automatic mp_op_e op_after_bit(input logic last_bit);
        return last_bit ? OPX1 : OPXX;
    endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/result and Montgomery-unit handshake signals of the exponentiation controller.
// The slave modport is the controller's view; master is the host/Montgomery side.
interface mod_exp_ctrl_if #(
    parameter int unsigned BITLEN = 512,
    parameter int unsigned ELEN_W = 10
);
    logic              start;
    logic [BITLEN-1:0] E;
    logic [ELEN_W-1:0] e_len;
    logic [BITLEN-1:0] result;
    logic              busy;
    logic              done;
    logic              err;

    logic              mp_start;
    logic [1:0]        mp_op_code;
    logic              mp_stop;
    logic [BITLEN:0]   mp_P;

    modport slave (
        input  start, E, e_len, mp_stop, mp_P,
        output result, busy, done, err, mp_start, mp_op_code
    );

    modport master (
        output start, E, e_len, mp_stop, mp_P,
        input  result, busy, done, err, mp_start, mp_op_code
    );

endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery product unit.
// Every exponent bit gets a square (accumulator starts at Montgomery one), then a final OPX1.
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned BITLEN = 512,
    parameter int unsigned ELEN_W = 10
) (
    input logic           clk,
    input logic           rst_n,
    mod_exp_ctrl_if.slave bus
);

    localparam int unsigned IdxW = (BITLEN > 1) ? $clog2(BITLEN) : 1;

    typedef logic [IdxW-1:0]   idx_t;
    typedef logic [ELEN_W-1:0] elen_t;

    state_e            state_q;
    mp_op_e            op_q;
    idx_t              i_q;
    logic [BITLEN-1:0] e_q;
    logic [BITLEN-1:0] result_q;
    logic              mp_start_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic len_too_big;
    logic len_zero;
    logic e_bit;
    logic i_zero;

    assign len_too_big = 32'(bus.e_len) > BITLEN;
    assign len_zero    = (bus.e_len == '0);
    assign e_bit       = e_q[i_q];
    assign i_zero      = (i_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OPXX;
            i_q        <= '0;
            e_q        <= '0;
            result_q   <= '0;
            mp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        e_q    <= bus.E;
                        if (len_too_big) begin
                            // Rejected request: no ops, result untouched, done on the next cycle.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            err_q      <= 1'b0;
                            mp_start_q <= 1'b1;
                            state_q    <= StIssue;
                            if (len_zero) begin
                                op_q <= OPX1;
                                i_q  <= '0;
                            end else begin
                                op_q <= OPXX;
                                i_q  <= idx_t'(bus.e_len - elen_t'(1));
                            end
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.mp_stop) begin
                        mp_start_q <= 1'b0;
                        state_q    <= StGap;
                        if (op_q == OPX1) begin
                            result_q <= bus.mp_P[BITLEN-1:0];
                        end
                    end
                end
                StGap: begin
                    // mp_stop may still be high here from the finished op; it is not looked at.
                    state_q <= StNext;
                end
                StNext: begin
                    if (op_q == OPX1) begin
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        mp_start_q <= 1'b1;
                        state_q    <= StIssue;
                        if (op_q == OPXX && e_bit) begin
                            op_q <= OPXM;
                        end else begin
                            op_q <= op_after_bit(i_zero);
                            if (!i_zero) begin
                                i_q <= i_q - idx_t'(1);
                            end
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    mp_start_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.mp_start   = mp_start_q;
    assign bus.mp_op_code = op_q;
    assign bus.result     = result_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery unit (M=589, base 435, R=2^10).
// Expected op sequences and results are hand-computed powers of 435 mod 589.
module tb_mod_exp_ctrl;
    import mod_exp_ctrl_pkg::*;

    localparam int unsigned BITLEN  = 10;
    localparam int unsigned ELEN_W  = 5;
    localparam int unsigned MOD     = 589;
    localparam int unsigned BASE    = 435;
    localparam int unsigned LATENCY = 8;
    localparam int unsigned R_MOD_M = (1 << BITLEN) % MOD;
    localparam int unsigned XBAR    = (BASE * (1 << BITLEN)) % MOD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mod_exp_ctrl_if #(.BITLEN(BITLEN), .ELEN_W(ELEN_W)) bus ();

    mod_exp_ctrl #(.BITLEN(BITLEN), .ELEN_W(ELEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // a*b*2^-BITLEN mod MOD by bit-serial reduction
    function automatic int unsigned mont(input int unsigned a, input int unsigned b);
        longint unsigned t;
        t = longint'(a) * longint'(b);
        for (int k = 0; k < int'(BITLEN); k++) begin
            if (t[0]) t = t + MOD;
            t = t >> 1;
        end
        if (t >= MOD) t = t - MOD;
        return int'(t);
    endfunction

    function automatic int unsigned model_op(input int unsigned acc, input logic [1:0] op);
        case (op)
            2'd0:    return mont(acc, acc);
            2'd1:    return mont(acc, XBAR);
            default: return mont(acc, 1);
        endcase
    endfunction

    // Behavioural Montgomery unit, plus op/done logging for the checks.
    int unsigned acc;
    int          cnt;
    logic        active;
    logic [1:0]  cur_op;
    int          op_cnt;
    logic [1:0]  op_hist [16];
    int          done_cnt;
    int          stab_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mp_stop <= 1'b0;
            bus.mp_P    <= '0;
            active      <= 1'b0;
            cnt         <= 0;
            cur_op      <= 2'd0;
            acc         <= R_MOD_M;
            op_cnt      <= 0;
            done_cnt    <= 0;
            stab_err    <= 0;
        end else begin
            if (bus.start && !bus.busy) begin
                acc      <= R_MOD_M;
                op_cnt   <= 0;
                done_cnt <= 0;
                stab_err <= 0;
            end
            if (bus.done) done_cnt <= done_cnt + 1;
            if (!bus.mp_start) begin
                bus.mp_stop <= 1'b0;
                active      <= 1'b0;
            end else if (!active && !bus.mp_stop) begin
                active <= 1'b1;
                cnt    <= 1;
                cur_op <= bus.mp_op_code;
                if (op_cnt < 16) op_hist[op_cnt] <= bus.mp_op_code;
                op_cnt <= op_cnt + 1;
            end else if (active) begin
                if (bus.mp_op_code != cur_op) stab_err <= stab_err + 1;
                if (cnt == int'(LATENCY) - 1) begin
                    active      <= 1'b0;
                    bus.mp_stop <= 1'b1;
                    acc         <= model_op(acc, cur_op);
                    bus.mp_P    <= (BITLEN + 1)'(model_op(acc, cur_op));
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // Starts a request; optionally re-pulses start once op number repulse_at is in flight.
    task automatic run_exp(input logic [BITLEN-1:0] e, input logic [ELEN_W-1:0] len,
                           input int repulse_at, output int done_cyc);
        logic seen;
        logic pulsed;
        seen     = 1'b0;
        pulsed   = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.E     = e;
        bus.e_len = len;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.start) bus.start = 1'b0;
            if (c == 0) begin
                bus.E     = ~e;
                bus.e_len = 5'd1;
            end
            if (bus.done) begin
                seen     = 1'b1;
                done_cyc = c;
                break;
            end
            if (repulse_at > 0 && !pulsed && op_cnt == repulse_at && bus.mp_start) begin
                bus.start = 1'b1;
                bus.E     = 10'd3;
                bus.e_len = 5'd2;
                pulsed    = 1'b1;
            end
        end
        check_val("done_seen", seen, 1'b1);
    endtask

    task automatic check_ops(input string tag, input int n, input logic [15:0] seq);
        check_val({tag, "_op_count"}, op_cnt, n);
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("%s_op%0d", tag, k), op_hist[k], seq[2*k +: 2]);
        end
    endtask

    task automatic check_after(input string tag, input logic [BITLEN-1:0] exp_result);
        check_val({tag, "_result"}, bus.result, exp_result);
        check_val({tag, "_busy_at_done"}, bus.busy, 1'b1);
        repeat (3) @(negedge clk);
        check_val({tag, "_busy_after"}, bus.busy, 1'b0);
        check_val({tag, "_done_after"}, bus.done, 1'b0);
        check_val({tag, "_done_pulses"}, done_cnt, 1);
        check_val({tag, "_opcode_stable"}, stab_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests_failed=%0d", tests_failed);
        $fatal(1);
    end

    initial begin
        int dc;
        bool_dummy: begin end
        bus.start = 1'b0;
        bus.E     = '0;
        bus.e_len = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_mp_start", bus.mp_start, 1'b0);
        check_val("rst_op_code", bus.mp_op_code, OPXX);
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_err", bus.err, 1'b0);
        check_val("rst_result", bus.result, 10'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 435^5 mod 589 = 63
        run_exp(10'd5, 5'd3, 0, dc);
        check_ops("e5", 6, 16'({OPX1, OPXM, OPXX, OPXX, OPXM, OPXX}));
        check_val("e5_err", bus.err, 1'b0);
        check_after("e5", 10'd63);

        // Empty exponent: a single OPX1 of Montgomery one gives 1.
        run_exp(10'd5, 5'd0, 0, dc);
        check_ops("elen0", 1, 16'(OPX1));
        check_after("elen0", 10'd1);

        // Over-long exponent: rejected, done one cycle after start, result kept.
        run_exp(10'd5, 5'(BITLEN + 1), 0, dc);
        check_val("toolong_done_cycle", dc, 0);
        check_val("toolong_err", bus.err, 1'b1);
        check_val("toolong_no_ops", op_cnt, 0);
        check_val("toolong_result", bus.result, 10'd1);
        repeat (3) @(negedge clk);
        check_val("toolong_busy_after", bus.busy, 1'b0);
        check_val("toolong_err_held", bus.err, 1'b1);

        // start re-pulsed during op 2 must be ignored.
        run_exp(10'd5, 5'd3, 2, dc);
        check_ops("repulse", 6, 16'({OPX1, OPXM, OPXX, OPXX, OPXM, OPXX}));
        check_val("repulse_err_cleared", bus.err, 1'b0);
        check_after("repulse", 10'd63);

        // Reset during op 3 abandons the run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.E     = 10'd5;
        bus.e_len = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            logic reached;
            reached = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (op_cnt == 3 && bus.mp_start && !bus.mp_stop) begin
                    reached = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_val("rst_mid_reached_op3", reached, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_mp_start", bus.mp_start, 1'b0);
        check_val("rst_mid_busy", bus.busy, 1'b0);
        check_val("rst_mid_result", bus.result, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 435^3 mod 589 = 125
        run_exp(10'd3, 5'd2, 0, dc);
        check_ops("e3", 5, 16'({OPX1, OPXM, OPXX, OPXM, OPXX}));
        check_after("e3", 10'd125);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
